// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared constants for the ALU control FSM and the datapath it steers.
// Holds state encodings, opcode/op field values, nsel/vsel encodings and the
// decoded instruction class.
package alu_ctrl_fsm_pkg;

  // FSM state encoding
  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_LOAD_A    = 3'd2;
  localparam logic [2:0] S_LOAD_B    = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_WRITE     = 3'd5;
  localparam logic [2:0] S_WRITE_IMM = 3'd6;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field IR[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // One-hot register-file select
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Write-back source select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } cls_e;

  function automatic cls_e classify(input logic [2:0] opcode, input logic [1:0] op);
    cls_e c;
    c = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      c = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) c = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  c = CLS_ADD;
        OP_CMP:  c = CLS_CMP;
        OP_AND:  c = CLS_AND;
        default: c = CLS_MVN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_instr_dec.sv
// instr_dec: combinational field extraction and legality check of the IR.
// Ports: ir_i (instruction register) -> cls_o (instruction class),
//        aluop_o IR[12:11], shift_o IR[4:3], sximm8_o IR[7:0] sign-extended.
module instr_dec
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir_i,
  output cls_e             cls_o,
  output logic [1:0]       aluop_o,
  output logic [1:0]       shift_o,
  output logic [WIDTH-1:0] sximm8_o
);

  logic [2:0] opcode;
  logic [1:0] op;
  logic [7:0] imm8;

  assign opcode   = ir_i[15:13];
  assign op       = ir_i[12:11];
  assign imm8     = ir_i[7:0];

  assign cls_o    = classify(opcode, op);
  assign aluop_o  = op;
  assign shift_o  = ir_i[4:3];
  assign sximm8_o = {{(WIDTH-8){imm8[7]}}, imm8};

  // Register numbers go straight to the register file, not through here.
  logic unused_regnums;
  assign unused_regnums = ^{ir_i[10:8], ir_i[2:0]};

endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: Moore controller sequencing a register-file/ALU datapath.
// Ports: clk, reset (async high), start/instr in; done, illegal, ALUop, nsel,
//        loada/b/c, loads, write, asel, vsel, shift, sximm8 out.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] instr,
  output logic             done,
  output logic             illegal,
  output logic [1:0]       ALUop,
  output logic [2:0]       nsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             asel,
  output logic [1:0]       vsel,
  output logic [1:0]       shift,
  output logic [WIDTH-1:0] sximm8
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             illegal_q, illegal_d;
  cls_e             cls;

  instr_dec #(.WIDTH(WIDTH)) u_dec (
    .ir_i     (ir_q),
    .cls_o    (cls),
    .aluop_o  (ALUop),
    .shift_o  (shift),
    .sximm8_o (sximm8)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // IR only loads on an accepted start, so it is stable for the whole instruction.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_WAIT: begin
        if (start) begin
          ir_d      = instr;
          illegal_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                  state_d = S_WRITE_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:    state_d = S_LOAD_A;
          CLS_MOV_REG, CLS_MVN:         state_d = S_LOAD_B;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_WAIT;
          end
        endcase
      end
      S_LOAD_A:    state_d = S_LOAD_B;
      S_LOAD_B:    state_d = S_EXEC;
      S_EXEC:      state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE;
      S_WRITE:     state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore outputs: every strobe defaults low and is raised only by its own state.
  always_comb begin
    nsel  = NSEL_NONE;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel  = 1'b0;
    vsel  = VSEL_C;
    case (state_q)
      S_LOAD_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_LOAD_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        // Single-operand ops pass B through the ALU with A forced to zero.
        asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        loads = (cls == CLS_CMP);
      end
      S_WRITE: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign done    = (state_q == S_WAIT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: per-cycle strobe sequences for each
// instruction class, busy-cycle counts, IR-derived outputs and async reset.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        done, illegal, loada, loadb, loadc, loads, write, asel;
  logic [1:0]  ALUop, vsel, shift;
  logic [2:0]  nsel;
  logic [15:0] sximm8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .instr   (instr),
    .done    (done),
    .illegal (illegal),
    .ALUop   (ALUop),
    .nsel    (nsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .write   (write),
    .asel    (asel),
    .vsel    (vsel),
    .shift   (shift),
    .sximm8  (sximm8)
  );

  // Packed view: {done, illegal, nsel[2:0], loada, loadb, loadc, loads, write, asel, vsel[1:0]}
  logic [12:0] outs;
  assign outs = {done, illegal, nsel, loada, loadb, loadc, loads, write, asel, vsel};

  localparam logic [12:0] E_WAIT     = 13'b1_0_000_0_0_0_0_0_0_00;
  localparam logic [12:0] E_WAIT_ILL = 13'b1_1_000_0_0_0_0_0_0_00;
  localparam logic [12:0] E_DEC      = 13'b0_0_000_0_0_0_0_0_0_00;
  localparam logic [12:0] E_LA       = 13'b0_0_100_1_0_0_0_0_0_00;
  localparam logic [12:0] E_LB       = 13'b0_0_001_0_1_0_0_0_0_00;
  localparam logic [12:0] E_EX       = 13'b0_0_000_0_0_1_0_0_0_00;
  localparam logic [12:0] E_EX_CMP   = 13'b0_0_000_0_0_1_1_0_0_00;
  localparam logic [12:0] E_EX_ASEL  = 13'b0_0_000_0_0_1_0_0_1_00;
  localparam logic [12:0] E_WR       = 13'b0_0_010_0_0_0_0_1_0_00;
  localparam logic [12:0] E_WRI      = 13'b0_0_100_0_0_0_0_1_0_10;

  logic [12:0] seq [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction and checks seq[0..n-1], one entry per cycle starting
  // with the S_DECODE cycle; the last entry is the return to S_WAIT.
  task automatic run_instr(input string name, input logic [15:0] ins, input bit hold,
                           input int n, input logic [1:0] exp_aluop,
                           input logic [1:0] exp_shift, input logic [15:0] exp_sx);
    int busy;
    busy = 0;
    @(negedge clk);
    start = 1'b1;
    instr = ins;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_cyc%0d", name, i), {19'd0, outs}, {19'd0, seq[i]});
      if (!done) busy++;
      if (i == 0) instr = ~ins;
      if (!hold || i == n - 2) start = 1'b0;
    end
    check({name, "_busy"},   busy,      n - 1);
    check({name, "_aluop"},  ALUop,     exp_aluop);
    check({name, "_shift"},  shift,     exp_shift);
    check({name, "_sximm8"}, sximm8,    exp_sx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b1;
    instr = 16'hA140;
    @(posedge clk);
    #1;
    check("reset_outs",   {19'd0, outs}, {19'd0, E_WAIT});
    check("reset_sximm8", sximm8, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", {19'd0, outs}, {19'd0, E_WAIT});

    // MOV R0,#-3
    seq[0] = E_DEC; seq[1] = E_WRI; seq[2] = E_WAIT;
    run_instr("movimm", 16'hD0FD, 1'b0, 3, 2'b10, 2'b11, 16'hFFFD);

    // ADD R2,R1,R0 with start held high while busy
    seq[0] = E_DEC; seq[1] = E_LA; seq[2] = E_LB; seq[3] = E_EX; seq[4] = E_WR; seq[5] = E_WAIT;
    run_instr("add_hold", 16'hA140, 1'b1, 6, 2'b00, 2'b00, 16'h0040);

    // CMP R3,R4
    seq[0] = E_DEC; seq[1] = E_LA; seq[2] = E_LB; seq[3] = E_EX_CMP; seq[4] = E_WAIT;
    run_instr("cmp", 16'hAB04, 1'b0, 5, 2'b01, 2'b00, 16'h0004);

    // MVN R5,R6 LSL#1
    seq[0] = E_DEC; seq[1] = E_LB; seq[2] = E_EX_ASEL; seq[3] = E_WR; seq[4] = E_WAIT;
    run_instr("mvn", 16'hB8AE, 1'b0, 5, 2'b11, 2'b01, 16'hFFAE);

    // MOV R5,R1
    run_instr("movreg", 16'hC0A1, 1'b0, 5, 2'b00, 2'b00, 16'hFFA1);

    // AND R0,R0,R0
    seq[0] = E_DEC; seq[1] = E_LA; seq[2] = E_LB; seq[3] = E_EX; seq[4] = E_WR; seq[5] = E_WAIT;
    run_instr("and", 16'hB000, 1'b0, 6, 2'b10, 2'b00, 16'h0000);

    // Unsupported opcode, then unsupported MOV op
    seq[0] = E_DEC; seq[1] = E_WAIT_ILL;
    run_instr("illegal_opc", 16'hE000, 1'b0, 2, 2'b00, 2'b00, 16'h0000);
    run_instr("illegal_mov", 16'hC800, 1'b0, 2, 2'b01, 2'b00, 16'h0000);

    // A legal instruction clears the sticky flag on acceptance
    seq[0] = E_DEC; seq[1] = E_WRI; seq[2] = E_WAIT;
    run_instr("clear_ill", 16'hD0FD, 1'b0, 3, 2'b10, 2'b11, 16'hFFFD);

    // Reset asserted mid-instruction in S_EXEC of ADD, start held high
    @(negedge clk);
    start = 1'b1;
    instr = 16'hA140;
    seq[0] = E_DEC; seq[1] = E_LA; seq[2] = E_LB; seq[3] = E_EX;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_run_cyc%0d", i), {19'd0, outs}, {19'd0, seq[i]});
    end
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_outs",   {19'd0, outs}, {19'd0, E_WAIT});
    check("rst_async_sximm8", sximm8, 16'h0000);
    check("rst_async_aluop",  ALUop,  2'b00);
    @(posedge clk);
    #1;
    check("rst_held_outs", {19'd0, outs}, {19'd0, E_WAIT});
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_after_cyc%0d", i), {19'd0, outs}, {19'd0, E_WAIT});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
